collision_scheduler: RTL and testbench

Sequences per-frame collision checks between game entities and the projectile bitmaps, which are held in on-chip RAM behind a single shared 1-cycle-latency read port. On each frame tick it latches all entity positions and walks enemy slots 0..N_ENEMIES-1, then the player. It reads one grid bit per entity at address 120*x+y and emits score and health update pulses plus a per-enemy hit vector for the game-state FSM.

---
 rtl/collision_scheduler.sv | 160 ++++++++++++++++
 tb/tb_collision_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Per-frame collision walk: enemy slots 0..N_ENEMIES-1, then the player, one grid bit per entity
// read through a shared 1-cycle-latency RAM port.
//
// state  | meaning
// IDLE   | waiting for a frame tick; positions are latched on start
// ADDR   | drive the grid address/select for the current entity, strobe grid_rd if checkable
// READ   | sample grid_data, record hit, advance to next entity
// FINISH | publish hit vector, pulse done, drop busy
module collision_scheduler #(
  parameter int N_ENEMIES = 4,
  parameter int GRID_W    = 160,
  parameter int GRID_H    = 120,
  parameter int ADDR_W    = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*N_ENEMIES-1:0] enemy_x,
  input  logic [7*N_ENEMIES-1:0] enemy_y,
  input  logic [N_ENEMIES-1:0]   enemy_valid,
  input  logic [7:0]             user_x,
  input  logic [6:0]             user_y,
  output logic [ADDR_W-1:0]      grid_addr,
  output logic                   grid_sel,
  output logic                   grid_rd,
  input  logic                   grid_data,
  output logic                   busy,
  output logic                   done,
  output logic [N_ENEMIES-1:0]   enemy_hit,
  output logic                   current_score_update,
  output logic                   current_health_update
);

  localparam int IDX_W = $clog2(N_ENEMIES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_READ   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [IDX_W-1:0]  PLAYER_IDX = IDX_W'(N_ENEMIES);
  localparam logic [8:0]        X_LIMIT    = 9'(GRID_W);
  localparam logic [7:0]        Y_LIMIT    = 8'(GRID_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(GRID_H);

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [8*N_ENEMIES-1:0] ex_q;
  logic [7*N_ENEMIES-1:0] ey_q;
  logic [N_ENEMIES-1:0]   ev_q;
  logic [7:0]             ux_q;
  logic [6:0]             uy_q;
  logic [N_ENEMIES-1:0]   acc;
  logic                   grid_rd_q;

  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic              sel_v;
  logic              is_player;
  logic              in_bounds;
  logic              rd_int;
  logic              hit;
  logic [ADDR_W-1:0] addr_calc;

  assign is_player = (idx == PLAYER_IDX);

  // Loop mux rather than a variable part-select: idx legitimately reaches N_ENEMIES.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_v = 1'b0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_x = ex_q[8*i +: 8];
        sel_y = ey_q[7*i +: 7];
        sel_v = ev_q[i];
      end
    end
    if (is_player) begin
      sel_x = ux_q;
      sel_y = uy_q;
      sel_v = 1'b1;
    end
  end

  assign in_bounds = ({1'b0, sel_x} < X_LIMIT) && ({1'b0, sel_y} < Y_LIMIT);
  assign addr_calc = ROW_STRIDE * ADDR_W'(sel_x) + ADDR_W'(sel_y);
  assign rd_int    = (state == S_ADDR) && in_bounds && sel_v;

  assign grid_rd   = rd_int;
  assign grid_sel  = (state == S_ADDR) && is_player;
  assign grid_addr = (state == S_ADDR) ? addr_calc : '0;

  // Skipped entities never strobe the RAM, so a stale grid_data cannot register a hit.
  assign hit = grid_rd_q & grid_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= S_IDLE;
      idx                   <= '0;
      ex_q                  <= '0;
      ey_q                  <= '0;
      ev_q                  <= '0;
      ux_q                  <= '0;
      uy_q                  <= '0;
      acc                   <= '0;
      grid_rd_q             <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      enemy_hit             <= '0;
      current_score_update  <= 1'b0;
      current_health_update <= 1'b0;
    end else begin
      done                  <= 1'b0;
      current_score_update  <= 1'b0;
      current_health_update <= 1'b0;
      grid_rd_q             <= rd_int;
      case (state)
        S_IDLE: begin
          if (start) begin
            ex_q  <= enemy_x;
            ey_q  <= enemy_y;
            ev_q  <= enemy_valid;
            ux_q  <= user_x;
            uy_q  <= user_y;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= S_READ;
        end
        S_READ: begin
          if (is_player) begin
            current_health_update <= hit;
            state                 <= S_FINISH;
          end else begin
            current_score_update <= hit;
            for (int i = 0; i < N_ENEMIES; i++) begin
              if (hit && (idx == IDX_W'(i))) acc[i] <= 1'b1;
            end
            idx   <= idx + 1'b1;
            state <= S_ADDR;
          end
        end
        S_FINISH: begin
          enemy_hit <= acc;
          done      <= 1'b1;
          busy      <= 1'b0;
          idx       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: table of frame scans plus restart and reset-abort sequences.
module tb_collision_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] enemy_x;
  logic [27:0] enemy_y;
  logic [3:0]  enemy_valid;
  logic [7:0]  user_x;
  logic [6:0]  user_y;
  logic [14:0] grid_addr;
  logic        grid_sel;
  logic        grid_rd;
  logic        grid_data;
  logic        busy;
  logic        done;
  logic [3:0]  enemy_hit;
  logic        current_score_update;
  logic        current_health_update;

  always #5 clock = ~clock;

  collision_scheduler dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .enemy_x               (enemy_x),
    .enemy_y               (enemy_y),
    .enemy_valid           (enemy_valid),
    .user_x                (user_x),
    .user_y                (user_y),
    .grid_addr             (grid_addr),
    .grid_sel              (grid_sel),
    .grid_rd               (grid_rd),
    .grid_data             (grid_data),
    .busy                  (busy),
    .done                  (done),
    .enemy_hit             (enemy_hit),
    .current_score_update  (current_score_update),
    .current_health_update (current_health_update)
  );

  bit   pbg [0:19199];
  bit   ebg [0:19199];
  logic stale = 1'b0;

  // Grid RAM model: one-cycle read latency; returns the stale value when not strobed.
  always @(posedge clock) begin
    if (grid_rd && grid_addr < 15'd19200) grid_data <= grid_sel ? ebg[grid_addr] : pbg[grid_addr];
    else grid_data <= stale;
  end

  typedef struct {
    logic [31:0] ex;
    logic [27:0] ey;
    logic [3:0]  ev;
    logic [7:0]  ux;
    logic [6:0]  uy;
    int          pb0;
    int          pb1;
    int          eb;
    logic        stale;
    logic [4:0]  exp_rd;
    logic [3:0]  exp_hit;
    logic        exp_health;
  } vec_t;

  vec_t vecs [0:4];
  vec_t v5;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rec_rd, rec_sel, rec_done, rec_score, rec_health, rec_busy;
  logic [14:0] rec_addr [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic load_grid(input vec_t v);
    for (int a = 0; a < 19200; a++) begin
      pbg[a] = 1'b0;
      ebg[a] = 1'b0;
    end
    if (v.pb0 >= 0) pbg[v.pb0] = 1'b1;
    if (v.pb1 >= 0) pbg[v.pb1] = 1'b1;
    if (v.eb  >= 0) ebg[v.eb]  = 1'b1;
    stale = v.stale;
  endtask

  // Record index c holds the outputs after the c-th edge following the start edge.
  task automatic do_scan(input vec_t v, input int restart_at, input logic [31:0] alt_ex,
                         input int reset_at);
    load_grid(v);
    @(negedge clock);
    enemy_x     = v.ex;
    enemy_y     = v.ey;
    enemy_valid = v.ev;
    user_x      = v.ux;
    user_y      = v.uy;
    start       = 1'b1;
    @(posedge clock);
    rec_rd = '0; rec_sel = '0; rec_done = '0; rec_score = '0; rec_health = '0; rec_busy = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      rec_rd[c]     = grid_rd;
      rec_sel[c]    = grid_sel;
      rec_done[c]   = done;
      rec_score[c]  = current_score_update;
      rec_health[c] = current_health_update;
      rec_busy[c]   = busy;
      rec_addr[c]   = grid_addr;
      start = (c == restart_at);
      if (c == restart_at) enemy_x = alt_ex;
      reset = (c == reset_at);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic verify(input vec_t v, input string tag);
    logic [15:0] e_rd, e_score, e_health;
    logic [31:0] ea;
    e_rd = '0;
    e_score = '0;
    for (int k = 0; k < 5; k++) if (v.exp_rd[k]) e_rd[2*k] = 1'b1;
    for (int k = 0; k < 4; k++) if (v.exp_hit[k]) e_score[2*k+2] = 1'b1;
    e_health = v.exp_health ? 16'h0400 : 16'h0000;
    chk({tag, "_rd_pattern"},     32'(rec_rd),     32'(e_rd));
    chk({tag, "_sel_pattern"},    32'(rec_sel),    32'h0100);
    chk({tag, "_score_pattern"},  32'(rec_score),  32'(e_score));
    chk({tag, "_health_pattern"}, 32'(rec_health), 32'(e_health));
    chk({tag, "_done_pattern"},   32'(rec_done),   32'h0800);
    chk({tag, "_busy_pattern"},   32'(rec_busy),   32'h07FF);
    for (int k = 0; k < 5; k++) begin
      if (v.exp_rd[k]) begin
        if (k < 4) ea = 32'(v.ex[8*k +: 8]) * 120 + 32'(v.ey[7*k +: 7]);
        else       ea = 32'(v.ux) * 120 + 32'(v.uy);
        chk($sformatf("%s_addr_e%0d", tag, k), 32'(rec_addr[2*k]), ea);
      end
    end
    chk({tag, "_enemy_hit"}, 32'(enemy_hit), 32'(v.exp_hit));
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    enemy_x     = '0;
    enemy_y     = '0;
    enemy_valid = '0;
    user_x      = '0;
    user_y      = '0;

    vecs[0] = '{{8'd7, 8'd5, 8'd3, 8'd1}, {7'd8, 7'd6, 7'd4, 7'd2}, 4'hF, 8'd9, 7'd10,
                -1, -1, -1, 1'b0, 5'b11111, 4'b0000, 1'b0};
    vecs[1] = '{{8'd7, 8'd10, 8'd3, 8'd1}, {7'd8, 7'd5, 7'd4, 7'd2}, 4'hF, 8'd9, 7'd10,
                1205, -1, -1, 1'b0, 5'b11111, 4'b0100, 1'b0};
    vecs[2] = '{{8'd7, 8'd5, 8'd3, 8'd10}, {7'd8, 7'd6, 7'd4, 7'd5}, 4'h0, 8'd80, 7'd100,
                1205, -1, 9700, 1'b0, 5'b10000, 4'b0000, 1'b1};
    vecs[3] = '{{8'd0, 8'd3, 8'd160, 8'd1}, {7'd120, 7'd4, 7'd0, 7'd2}, 4'hF, 8'd9, 7'd10,
                120, -1, -1, 1'b1, 5'b10101, 4'b0000, 1'b0};
    vecs[4] = '{{8'd159, 8'd5, 8'd3, 8'd0}, {7'd119, 7'd6, 7'd4, 7'd0}, 4'hF, 8'd159, 7'd119,
                0, 19199, 19199, 1'b0, 5'b11111, 4'b1001, 1'b1};
    v5      = '{{8'd159, 8'd5, 8'd3, 8'd1}, {7'd119, 7'd6, 7'd4, 7'd2}, 4'hF, 8'd9, 7'd10,
                -1, 19199, -1, 1'b0, 5'b11111, 4'b1000, 1'b0};

    repeat (3) @(negedge clock);
    chk("rst_busy",      32'(busy),                  32'd0);
    chk("rst_done",      32'(done),                  32'd0);
    chk("rst_grid_rd",   32'(grid_rd),               32'd0);
    chk("rst_grid_sel",  32'(grid_sel),              32'd0);
    chk("rst_grid_addr", 32'(grid_addr),             32'd0);
    chk("rst_enemy_hit", 32'(enemy_hit),             32'd0);
    chk("rst_score",     32'(current_score_update),  32'd0);
    chk("rst_health",    32'(current_health_update), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_scan(vecs[i], -1, 32'd0, -1);
      verify(vecs[i], $sformatf("vec%0d", i));
      if (i == 1) chk("vec1_slot2_addr_1205", 32'(rec_addr[4]), 32'd1205);
    end

    // Second start 3 cycles in, with slot 2 moved to a position that would not hit.
    do_scan(vecs[1], 3, {8'd7, 8'd20, 8'd3, 8'd1}, -1);
    verify(vecs[1], "restart_mid");

    // Start during FINISH must be dropped.
    do_scan(vecs[1], 10, vecs[1].ex, -1);
    verify(vecs[1], "restart_finish");

    // Reset at cycle 5 of a scan where slot 3 would hit.
    do_scan(v5, -1, 32'd0, 5);
    chk("abort_busy_next",  32'(rec_busy[6]), 32'd0);
    chk("abort_busy_patt",  32'(rec_busy),    32'h003F);
    chk("abort_rd_patt",    32'(rec_rd),      32'h0015);
    chk("abort_score_patt", 32'(rec_score),   32'd0);
    chk("abort_done_patt",  32'(rec_done),    32'd0);
    chk("abort_enemy_hit",  32'(enemy_hit),   32'd0);

    do_scan(vecs[4], -1, 32'd0, -1);
    verify(vecs[4], "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
